maq_mh: RTL
===========

# maq_mh

Minutes-and-hours counter for the digital clock, sitting directly downstream of the seconds counter. It consumes the one-cycle `incrementa_minuto` carry pulse and keeps the time of day as BCD digits in 24-hour format, 00:00 to 23:59. It also provides a manual time-set mode driven by two debounced push-buttons. It emits a one-cycle `incrementa_dia` carry on the normal-count rollover from 23:59 to 00:00.

## Interface
- `HORA_INICIAL`, default 0: hour loaded on reset. Legal range 0..23; binary value, converted to BCD at elaboration.
- `MIN_INICIAL`, default 0: minute loaded on reset. Legal range 0..59.
- `clock` input 1: single system clock; all state is on its rising edge.
- `reset` input 1: asynchronous, active-high; clears or loads all state immediately.
- `incrementa_minuto` input 1: one-cycle carry pulse from the seconds counter.
- `ajuste` input 1: level; 1 = time-set mode.
- `btn_min` input 1: debounced level; a rising edge advances the minutes in set mode.
- `btn_hora` input 1: debounced level; a rising edge advances the hours in set mode.
- `bcd_m_lsd` output 4: minutes units, 0..9.
- `bcd_m_msd` output 3: minutes tens, 0..5.
- `bcd_h_lsd` output 4: hours units, 0..9 (0..3 when tens = 2).
- `bcd_h_msd` output 2: hours tens, 0..2.
- `incrementa_dia` output 1: one-cycle day-carry pulse.

## Operation
- **Reset:**
  - Minute digits = BCD of `MIN_INICIAL`; hour digits = BCD of `HORA_INICIAL`.
  - `incrementa_dia` = 0.
  - Both button-history flops = 1, so a button held through reset release does not fire.
- **Normal mode (`ajuste` = 0):**
  - On `incrementa_minuto` = 1, advance the minutes:
    - units 9 → 0 and tens +1;
    - 59 → 00 with a carry into the hours.
  - Hours carry:
    - units 9 → 0 and tens +1;
    - 23 → 00.
  - `incrementa_dia` = 1 only on the 23:59 → 00:00 step.
  - Buttons are ignored, but their history flops keep tracking the inputs.
- **Set mode (`ajuste` = 1):**
  - `incrementa_minuto` is ignored; time is frozen apart from the buttons.
  - `btn_min` rising edge (current 1, previous 0): minutes +1, 59 → 00, no carry into the hours.
  - `btn_hora` rising edge: hours +1, 23 → 00.
  - `incrementa_dia` stays 0 in this mode.
  - Both edges in the same cycle: both fields advance independently.
- **Mode changes:**
  - Changing `ajuste` takes effect on the next rising edge.
  - A carry that coincides with the edge where `ajuste` is sampled as 1 is dropped, not queued.
- **Counter legality:** the counters never hold illegal BCD. Any illegal digit value, which is unreachable by design, is treated as the wrap value, i.e. next value 0.

## Timing
- Inputs are sampled on the rising edge of `clock`. Digit outputs are registered and update on the edge that samples the event; the new value is visible in the following cycle.
- Zero-cycle decision latency: an `incrementa_minuto` pulse in cycle N produces new digits in cycle N+1.
- `incrementa_dia` is registered and goes high on the same edge that loads 00:00. It is high for exactly one cycle, then returns to 0 unless another rollover occurs.
- Back-to-back `incrementa_minuto` pulses on consecutive cycles are each counted; there is no rate limit.
- Button-edge detection adds no extra cycle beyond the history flop: the edge is seen on the first clock where the input is 1 and the history flop is 0.
- Asserting `reset` mid-count forces the reset values asynchronously, including in the middle of a `incrementa_dia` pulse, which is cut short.

## Structure
- Shared package `relogio_pkg`:
  - digit widths: `W_LSD` = 4, `W_M_MSD` = 3, `W_H_MSD` = 2;
  - limits: `MAX_MIN` = 59, `MAX_HORA` = 23;
  - a binary-to-BCD constant function used for the parameter conversion.
- The seconds counter also uses `relogio_pkg`.
- One sub-module, `contador_bcd_2d`, is natural:
  - a two-digit BCD counter with inputs `inc` and `max_msd`/`max_lsd`, and output `wrap`;
  - `maq_mh` instantiates it twice, once for minutes (59) and once for hours (23);
  - `maq_mh` adds the mode muxing, button edge detection and the `incrementa_dia` register.

## Test plan
- **Reset defaults:** reset with the default parameters → 00:00 and `incrementa_dia` = 0. Repeat with `HORA_INICIAL` = 13, `MIN_INICIAL` = 45 → 13:45.
- **Minute carry:** at 09:59, one `incrementa_minuto` → 10:00 next cycle; at 19:59 → 20:00; at 12:09 → 12:10.
- **Day rollover:** at 23:59, one pulse → 00:00, with `incrementa_dia` high for exactly one cycle. Then 1440 pulses → 00:00 again with a second single `incrementa_dia`.
- **Set mode:**
  - `ajuste` = 1 at 10:59, `btn_min` edge → 10:00 (no hour carry); `btn_hora` edge at 23:xx → 00:xx, `incrementa_dia` stays 0.
  - Simultaneous edges at 05:07 → 06:08.
  - `incrementa_minuto` pulses in this mode → no change.
- **Boundary cases:**
  - Button held high across reset release → no advance.
  - Pulses on 3 consecutive cycles from 00:58 → 01:01.
  - Async reset asserted mid-cycle during an `incrementa_dia` pulse → outputs immediately at their reset values.

Source files
------------

// File: rtl/relogio_pkg.sv
// relogio_pkg: constants and helpers shared by the clock counters
// (seconds, minutes and hours).
//   W_LSD / W_M_MSD / W_H_MSD : BCD digit widths
//   MAX_MIN / MAX_HORA        : highest legal minute / hour
//   bin2bcd                   : binary 0..99 to packed two-digit BCD {tens, units},
//                               used at elaboration only
package relogio_pkg;

  localparam int W_LSD   = 4;
  localparam int W_M_MSD = 3;
  localparam int W_H_MSD = 2;

  localparam int unsigned MAX_MIN  = 59;
  localparam int unsigned MAX_HORA = 23;

  function automatic logic [7:0] bin2bcd(input int unsigned v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 10);
    units = 4'(v % 10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/contador_bcd_2d.sv
// contador_bcd_2d: two-digit BCD up-counter with a programmable terminal value.
//   clock, reset    : rising-edge clock, async active-high reset (loads INIT_*)
//   inc             : advance by one on this edge
//   max_msd/max_lsd : terminal value; the next step after it is 00
//   lsd, msd        : registered BCD digits
//   wrap            : combinational, high when inc is taken at the terminal value
module contador_bcd_2d
  import relogio_pkg::*;
#(
  parameter int          W_MSD    = 3,
  parameter int unsigned INIT_MSD = 0,
  parameter int unsigned INIT_LSD = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic [W_MSD-1:0] max_msd,
  input  logic [W_LSD-1:0] max_lsd,
  output logic [W_LSD-1:0] lsd,
  output logic [W_MSD-1:0] msd,
  output logic             wrap
);

  logic at_max;

  // Anything at or past the terminal value (including unreachable illegal
  // codes) wraps to 00, so the counter can never get stuck on a bad value.
  assign at_max = (msd > max_msd) || ((msd == max_msd) && (lsd >= max_lsd));
  assign wrap   = inc & at_max;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lsd <= W_LSD'(INIT_LSD);
      msd <= W_MSD'(INIT_MSD);
    end else if (inc) begin
      if (at_max) begin
        lsd <= '0;
        msd <= '0;
      end else if (lsd >= W_LSD'(9)) begin
        lsd <= '0;
        msd <= msd + W_MSD'(1);
      end else begin
        lsd <= lsd + W_LSD'(1);
      end
    end
  end

endmodule

// File: rtl/maq_mh.sv
// maq_mh: minutes/hours time-of-day counter (24 h, BCD) with manual set mode.
//   clock, reset        : rising-edge clock, async active-high reset
//   incrementa_minuto   : one-cycle carry from the seconds counter
//   ajuste              : 1 = set mode (carries ignored, buttons active)
//   btn_min, btn_hora   : debounced buttons, rising edge advances the field
//   bcd_m_lsd/bcd_m_msd : minute digits
//   bcd_h_lsd/bcd_h_msd : hour digits
//   incrementa_dia      : registered one-cycle pulse on 23:59 -> 00:00
module maq_mh
  import relogio_pkg::*;
#(
  parameter int unsigned HORA_INICIAL = 0,
  parameter int unsigned MIN_INICIAL  = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               incrementa_minuto,
  input  logic               ajuste,
  input  logic               btn_min,
  input  logic               btn_hora,
  output logic [W_LSD-1:0]   bcd_m_lsd,
  output logic [W_M_MSD-1:0] bcd_m_msd,
  output logic [W_LSD-1:0]   bcd_h_lsd,
  output logic [W_H_MSD-1:0] bcd_h_msd,
  output logic               incrementa_dia
);

  localparam logic [7:0] INIT_H_BCD = bin2bcd(HORA_INICIAL);
  localparam logic [7:0] INIT_M_BCD = bin2bcd(MIN_INICIAL);
  localparam logic [7:0] MAX_M_BCD  = bin2bcd(MAX_MIN);
  localparam logic [7:0] MAX_H_BCD  = bin2bcd(MAX_HORA);

  logic btn_min_q;
  logic btn_hora_q;
  logic edge_min;
  logic edge_hora;
  logic inc_min;
  logic inc_hora;
  logic wrap_min;
  logic wrap_hora;

  assign edge_min  = btn_min  & ~btn_min_q;
  assign edge_hora = btn_hora & ~btn_hora_q;

  // In set mode each field advances on its own button with no carry between
  // them; in normal mode the hour only moves on the minute wrap.
  assign inc_min  = ajuste ? edge_min  : incrementa_minuto;
  assign inc_hora = ajuste ? edge_hora : (incrementa_minuto & wrap_min);

  contador_bcd_2d #(
    .W_MSD    (W_M_MSD),
    .INIT_MSD (int'(INIT_M_BCD[7:4])),
    .INIT_LSD (int'(INIT_M_BCD[3:0]))
  ) u_min (
    .clock   (clock),
    .reset   (reset),
    .inc     (inc_min),
    .max_msd (MAX_M_BCD[W_M_MSD+3:4]),
    .max_lsd (MAX_M_BCD[3:0]),
    .lsd     (bcd_m_lsd),
    .msd     (bcd_m_msd),
    .wrap    (wrap_min)
  );

  contador_bcd_2d #(
    .W_MSD    (W_H_MSD),
    .INIT_MSD (int'(INIT_H_BCD[7:4])),
    .INIT_LSD (int'(INIT_H_BCD[3:0]))
  ) u_hora (
    .clock   (clock),
    .reset   (reset),
    .inc     (inc_hora),
    .max_msd (MAX_H_BCD[W_H_MSD+3:4]),
    .max_lsd (MAX_H_BCD[3:0]),
    .lsd     (bcd_h_lsd),
    .msd     (bcd_h_msd),
    .wrap    (wrap_hora)
  );

  // History flops reset to 1 so a button held through reset is not an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_min_q      <= 1'b1;
      btn_hora_q     <= 1'b1;
      incrementa_dia <= 1'b0;
    end else begin
      btn_min_q      <= btn_min;
      btn_hora_q     <= btn_hora;
      incrementa_dia <= ~ajuste & incrementa_minuto & wrap_min & wrap_hora;
    end
  end

endmodule
